// File: rtl/piece_dropper_pkg.sv
`default_nettype none
// ============================================================================
// Module : connect4_pkg
// Brief  : Shared board geometry, widths, FSM states and cell indexing.
// Rev    : 1.0
// ============================================================================
package connect4_pkg;

    localparam int ROWS  = 6;
    localparam int COLS  = 7;
    localparam int CELLS = ROWS * COLS;
    localparam int ROW_W = 3;
    localparam int COL_W = 3;
    localparam int CNT_W = 6;

    localparam logic [ROW_W-1:0] c_row_last = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] c_col_last = COL_W'(COLS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_FALL   = 2'd2,
        ST_REJECT = 2'd3
    } state_t;

    // Row 0 is the top row, so the bottom-left cell is bit COLS*(ROWS-1).
    function automatic logic [CNT_W-1:0] cell_index(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        return CNT_W'(int'(col) + COLS * int'(row));
    endfunction

endpackage
`default_nettype wire

// File: rtl/piece_dropper_if.sv
`default_nettype none
// ============================================================================
// Module : piece_dropper_if
// Brief  : Controller <-> piece dropper handshake and board encoding bundle.
// Rev    : 1.0
// ============================================================================
interface piece_dropper_if
    import connect4_pkg::*;
();

    logic             new_game;
    logic             drop_req;
    logic [COL_W-1:0] drop_col;
    logic             tick_en;
    logic             busy;
    logic             drop_ack;
    logic             drop_ok;
    logic [CELLS-1:0] red_enc;
    logic [CELLS-1:0] yellow_enc;
    logic             red_turn;
    logic             board_full;
    logic             fall_valid;
    logic [ROW_W-1:0] fall_row;
    logic [COL_W-1:0] fall_col;

    modport master (
        output new_game, drop_req, drop_col, tick_en,
        input  busy, drop_ack, drop_ok, red_enc, yellow_enc, red_turn,
               board_full, fall_valid, fall_row, fall_col
    );

    modport slave (
        input  new_game, drop_req, drop_col, tick_en,
        output busy, drop_ack, drop_ok, red_enc, yellow_enc, red_turn,
               board_full, fall_valid, fall_row, fall_col
    );

endinterface
`default_nettype wire

// File: rtl/piece_dropper_column_probe.sv
`default_nettype none
// ============================================================================
// Module : column_probe
// Brief  : Combinational occupancy lookup of one board cell.
// Rev    : 1.0
// ============================================================================
module column_probe
    import connect4_pkg::*;
(
    input  wire logic [CELLS-1:0] i_red_enc,
    input  wire logic [CELLS-1:0] i_yellow_enc,
    input  wire logic [ROW_W-1:0] i_row,
    input  wire logic [COL_W-1:0] i_col,
    output logic                  o_occ
);

    logic [CELLS-1:0] w_occ_map;
    logic [CNT_W-1:0] w_idx;

    assign w_occ_map = i_red_enc | i_yellow_enc;
    assign w_idx     = cell_index(i_row, i_col);
    assign o_occ     = w_occ_map[w_idx];

endmodule
`default_nettype wire

// File: rtl/piece_dropper.sv
`default_nettype none
// ============================================================================
// Module : piece_dropper
// Brief  : Drops pieces into a Connect-4 board; owns red/yellow encodings.
//          Optional falling-piece animation enabled by macro DROP_ANIM_EN.
// Rev    : 1.0
// ============================================================================
module piece_dropper
    import connect4_pkg::*;
(
    input  wire logic           clk,
    input  wire logic           rst_n,
    piece_dropper_if.slave      bus
);

    state_t           r_state, w_state_nxt;
    logic [COL_W-1:0] r_col, w_col_nxt;
    logic [ROW_W-1:0] r_row, w_row_nxt;
    logic [CELLS-1:0] r_red, w_red_nxt;
    logic [CELLS-1:0] r_yel, w_yel_nxt;
    logic             r_red_turn, w_red_turn_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_ack, w_ack_nxt;
    logic             r_ok, w_ok_nxt;
    logic             w_commit;
    logic             w_occ;
    logic [CELLS-1:0] w_mask;

    column_probe u_probe (
        .i_red_enc    (r_red),
        .i_yellow_enc (r_yel),
        .i_row        (r_row),
        .i_col        (r_col),
        .o_occ        (w_occ)
    );

    assign w_mask = CELLS'(1) << cell_index(r_row, r_col);

`ifdef DROP_ANIM_EN
    logic             r_fall_valid, w_fall_valid_nxt;
    logic [ROW_W-1:0] r_fall_row, w_fall_row_nxt;
    logic [COL_W-1:0] r_fall_col, w_fall_col_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_col      <= '0;
            r_row      <= '0;
            r_red      <= '0;
            r_yel      <= '0;
            r_red_turn <= 1'b1;
            r_cnt      <= '0;
            r_ack      <= 1'b0;
            r_ok       <= 1'b0;
`ifdef DROP_ANIM_EN
            r_fall_valid <= 1'b0;
            r_fall_row   <= '0;
            r_fall_col   <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            r_red      <= w_red_nxt;
            r_yel      <= w_yel_nxt;
            r_red_turn <= w_red_turn_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ack      <= w_ack_nxt;
            r_ok       <= w_ok_nxt;
`ifdef DROP_ANIM_EN
            r_fall_valid <= w_fall_valid_nxt;
            r_fall_row   <= w_fall_row_nxt;
            r_fall_col   <= w_fall_col_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_col_nxt      = r_col;
        w_row_nxt      = r_row;
        w_red_nxt      = r_red;
        w_yel_nxt      = r_yel;
        w_red_turn_nxt = r_red_turn;
        w_cnt_nxt      = r_cnt;
        w_ack_nxt      = 1'b0;
        w_ok_nxt       = r_ok;
        w_commit       = 1'b0;
`ifdef DROP_ANIM_EN
        w_fall_valid_nxt = r_fall_valid;
        w_fall_row_nxt   = r_fall_row;
        w_fall_col_nxt   = r_fall_col;
`endif

        if (bus.new_game) begin
            w_state_nxt    = ST_IDLE;
            w_red_nxt      = '0;
            w_yel_nxt      = '0;
            w_red_turn_nxt = 1'b1;
            w_cnt_nxt      = '0;
`ifdef DROP_ANIM_EN
            w_fall_valid_nxt = 1'b0;
            w_fall_row_nxt   = '0;
            w_fall_col_nxt   = '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.drop_req) begin
                        if (bus.drop_col > c_col_last) begin
                            w_state_nxt = ST_REJECT;
                        end else begin
                            w_col_nxt   = bus.drop_col;
                            w_row_nxt   = c_row_last;
                            w_state_nxt = ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    if (!w_occ) begin
`ifdef DROP_ANIM_EN
                        // Target row stays in r_row while the piece animates down.
                        w_state_nxt      = ST_FALL;
                        w_fall_valid_nxt = 1'b1;
                        w_fall_row_nxt   = '0;
                        w_fall_col_nxt   = r_col;
`else
                        w_commit = 1'b1;
`endif
                    end else if (r_row != '0) begin
                        w_row_nxt = r_row - ROW_W'(1);
                    end else begin
                        w_state_nxt = ST_REJECT;
                    end
                end
`ifdef DROP_ANIM_EN
                ST_FALL: begin
                    if (bus.tick_en) begin
                        if (r_fall_row == r_row) begin
                            w_commit         = 1'b1;
                            w_fall_valid_nxt = 1'b0;
                        end else begin
                            w_fall_row_nxt = r_fall_row + ROW_W'(1);
                        end
                    end
                end
`endif
                ST_REJECT: begin
                    w_ack_nxt   = 1'b1;
                    w_ok_nxt    = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase

            if (w_commit) begin
                if (r_red_turn) begin
                    w_red_nxt = r_red | w_mask;
                end else begin
                    w_yel_nxt = r_yel | w_mask;
                end
                w_red_turn_nxt = ~r_red_turn;
                w_cnt_nxt      = r_cnt + CNT_W'(1);
                w_ack_nxt      = 1'b1;
                w_ok_nxt       = 1'b1;
                w_state_nxt    = ST_IDLE;
            end
        end
    end

    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.drop_ack   = r_ack;
    assign bus.drop_ok    = r_ok;
    assign bus.red_enc    = r_red;
    assign bus.yellow_enc = r_yel;
    assign bus.red_turn   = r_red_turn;
    assign bus.board_full = (r_cnt == CNT_W'(CELLS));

`ifdef DROP_ANIM_EN
    assign bus.fall_valid = r_fall_valid;
    assign bus.fall_row   = r_fall_row;
    assign bus.fall_col   = r_fall_col;
`else
    logic w_unused_tick;
    assign w_unused_tick  = bus.tick_en;
    assign bus.fall_valid = 1'b0;
    assign bus.fall_row   = '0;
    assign bus.fall_col   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_piece_dropper.sv
`default_nettype none
// ============================================================================
// Module : tb_piece_dropper
// Brief  : Self-checking bench for piece_dropper against a 2-D board model.
// Rev    : 1.0
// ============================================================================
module tb_piece_dropper;

    localparam int R = 6;
    localparam int C = 7;
    localparam int N = R * C;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    piece_dropper_if bus();

    piece_dropper dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 0 = empty, 1 = red, 2 = yellow; row 0 is the top row
    int board [R][C];
    int height [C];
    bit m_red_turn;
    int moves;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] enc(input int who);
        logic [N-1:0] v;
        v = '0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                if (board[r][c] == who) v[c + C*r] = 1'b1;
        return v;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) board[r][c] = 0;
        for (int c = 0; c < C; c++) height[c] = 0;
        m_red_turn = 1'b1;
        moves      = 0;
    endtask

    task automatic check_board(input string tag);
        chk({tag, "_red_enc"},    64'(bus.red_enc),    64'(enc(1)));
        chk({tag, "_yellow_enc"}, 64'(bus.yellow_enc), 64'(enc(2)));
        chk({tag, "_red_turn"},   64'(bus.red_turn),   64'(m_red_turn));
        chk({tag, "_board_full"}, 64'(bus.board_full), 64'(moves == N));
    endtask

    task automatic new_game_pulse();
        @(negedge clk);
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
        model_clear();
        check_board("new_game");
    endtask

    task automatic do_drop(input int col, input bit poke);
        int  h, exp_lat, cyc;
        bit  valid, exp_ok;
        valid  = (col < C);
        h      = valid ? height[col] : 0;
        exp_ok = valid && (h < R);
`ifdef DROP_ANIM_EN
        exp_lat = valid ? R + 2 : 2;
`else
        exp_lat = !valid ? 2 : ((h == R) ? R + 2 : h + 2);
        bus.tick_en = 1'($urandom_range(0, 1));
`endif
        @(negedge clk);
        bus.drop_req = 1'b1;
        bus.drop_col = 3'(col);
        @(negedge clk);
        cyc = 1;
        if (poke) begin
            bus.drop_req = 1'b1;
            bus.drop_col = 3'($urandom_range(0, 7));
        end else begin
            bus.drop_req = 1'b0;
        end
        chk("busy_after_req", 64'(bus.busy), 64'd1);
        while (!bus.drop_ack && cyc < 40) begin
            @(negedge clk);
            bus.drop_req = 1'b0;
            cyc++;
        end
        chk("ack_seen",    64'(bus.drop_ack), 64'd1);
        chk("ack_latency", 64'(cyc),          64'(exp_lat));
        chk("drop_ok",     64'(bus.drop_ok),  64'(exp_ok));
`ifndef DROP_ANIM_EN
        chk("fall_tied", 64'({bus.fall_valid, bus.fall_row, bus.fall_col}), 64'd0);
`endif
        if (exp_ok) begin
            board[R-1-h][col] = m_red_turn ? 1 : 2;
            height[col]++;
            m_red_turn = !m_red_turn;
            moves++;
        end
        check_board("after_drop");
        @(negedge clk);
        chk("ack_one_cycle",  64'(bus.drop_ack), 64'd0);
        chk("idle_after_ack", 64'(bus.busy),     64'd0);
    endtask

    initial begin
        int iter;
        bit seen_ack;
        bus.new_game = 1'b0;
        bus.drop_req = 1'b0;
        bus.drop_col = '0;
`ifdef DROP_ANIM_EN
        bus.tick_en  = 1'b1;
`else
        bus.tick_en  = 1'b0;
`endif
        model_clear();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_red_enc",    64'(bus.red_enc),    64'd0);
        chk("rst_yellow_enc", 64'(bus.yellow_enc), 64'd0);
        chk("rst_red_turn",   64'(bus.red_turn),   64'd1);
        chk("rst_busy",       64'(bus.busy),       64'd0);
        chk("rst_ack_ok",     64'({bus.drop_ack, bus.drop_ok}), 64'd0);
        chk("rst_fall",       64'({bus.fall_valid, bus.fall_row, bus.fall_col}), 64'd0);
        chk("rst_board_full", 64'(bus.board_full), 64'd0);
        rst_n = 1'b1;

        // First drop into the centre column lands at bit 38
        do_drop(3, 1'b0);
        chk("bit38_only", 64'(bus.red_enc), 64'(N'(1) << 38));

        // Fill column 0, then one more that must reject
        new_game_pulse();
        for (int i = 0; i < 7; i++) do_drop(0, 1'b0);
        chk("col0_red",    64'(bus.red_enc),    64'(N'((1 << 35) | (1 << 21) | (1 << 7))));
        chk("col0_yellow", 64'(bus.yellow_enc), 64'(N'((1 << 28) | (1 << 14) | 1)));

        // Invalid column, with a request poked in while busy
        do_drop(7, 1'b1);
        do_drop(2, 1'b1);

        // Random play until the board is full
        new_game_pulse();
        iter = 0;
        while (moves < N && iter < 600) begin
            do_drop($urandom_range(0, 7), ($urandom_range(0, 3) == 0));
            iter++;
        end
        chk("full_moves",   64'(moves),                     64'(N));
        chk("full_flag",    64'(bus.board_full),            64'd1);
        chk("red_pop",      64'($countones(bus.red_enc)),    64'd21);
        chk("yellow_pop",   64'($countones(bus.yellow_enc)), 64'd21);
        chk("no_overlap",   64'(bus.red_enc & bus.yellow_enc), 64'd0);
        do_drop($urandom_range(0, 6), 1'b0);

        // new_game aborts a scan in progress
        new_game_pulse();
        for (int i = 0; i < 3; i++) do_drop(4, 1'b0);
        @(negedge clk);
        bus.drop_req = 1'b1;
        bus.drop_col = 3'd4;
        @(negedge clk);
        bus.drop_req = 1'b0;
        @(negedge clk);
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
        model_clear();
        chk("abort_busy", 64'(bus.busy),     64'd0);
        chk("abort_ack",  64'(bus.drop_ack), 64'd0);
        check_board("abort");
        seen_ack = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen_ack = seen_ack | bus.drop_ack;
        end
        chk("abort_no_late_ack", 64'(seen_ack), 64'd0);

`ifdef DROP_ANIM_EN
        // Animated drop into empty column 2 with a tick every 4 cycles
        begin
            int   rows_q[$];
            int   cyc;
            bit   prev_valid, prev_tick;
            int   prev_row;
            new_game_pulse();
            @(negedge clk);
            bus.tick_en  = 1'b0;
            bus.drop_req = 1'b1;
            bus.drop_col = 3'd2;
            cyc = 0;
            prev_valid = 1'b0;
            prev_tick  = 1'b0;
            prev_row   = -1;
            while (cyc < 200) begin
                @(negedge clk);
                cyc++;
                bus.drop_req = 1'b0;
                if (bus.drop_ack) break;
                if (bus.fall_valid) begin
                    chk("anim_fall_col", 64'(bus.fall_col), 64'd2);
                    if (rows_q.size() == 0 || rows_q[$] != int'(bus.fall_row))
                        rows_q.push_back(int'(bus.fall_row));
                end
                prev_valid  = bus.fall_valid;
                prev_row    = int'(bus.fall_row);
                bus.tick_en = (cyc % 4 == 0);
                prev_tick   = bus.tick_en;
            end
            bus.tick_en = 1'b1;
            chk("anim_ack_seen",   64'(bus.drop_ack),   64'd1);
            chk("anim_ok",         64'(bus.drop_ok),    64'd1);
            chk("anim_fall_drop",  64'(bus.fall_valid), 64'd0);
            chk("anim_prev_valid", 64'(prev_valid),     64'd1);
            chk("anim_prev_row",   64'(prev_row),       64'd5);
            chk("anim_prev_tick",  64'(prev_tick),      64'd1);
            chk("anim_bit37",      64'(bus.red_enc),    64'(N'(1) << 37));
            chk("anim_steps",      64'(rows_q.size()),  64'd6);
            for (int i = 0; i < rows_q.size(); i++)
                chk("anim_row_seq", 64'(rows_q[i]), 64'(i));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piece_dropper.md
Name: piece_dropper

Overview:
- Sequential writer of the Connect-4 board encoding; the pixel-side piece renderers are the readers of the same encoding.
- Accepts a column-drop request and scans that column upward from the bottom row for the lowest empty cell.
- Sets that cell's bit in the current player's vector, then alternates players.
- Sits between the input/game controller and the VGA piece-display logic; owns the red and yellow 42-bit occupancy vectors.

Parameters:
- ROWS, 6, board rows; row 0 is the top row.
- COLS, 7, board columns; column 0 is the left column.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- new_game  in  1  synchronous clear of board, player and move count
- drop_req  in  1  request to drop a piece; sampled only in IDLE
- drop_col  in  3  target column, 0..COLS-1
- busy  out  1  high whenever state is not IDLE
- drop_ack  out  1  one-cycle pulse when a request completes
- drop_ok  out  1  valid with drop_ack: 1 = placed, 0 = rejected
- red_enc  out  ROWS*COLS  red occupancy; bit index = col + COLS*row
- yellow_enc  out  ROWS*COLS  yellow occupancy; same indexing
- red_turn  out  1  1 when red places next
- board_full  out  1  high when move count equals ROWS*COLS
- tick_en  in  1  animation step strobe; used only with DROP_ANIM_EN
- fall_valid  out  1  falling piece visible (DROP_ANIM_EN)
- fall_row  out  3  row of falling piece (DROP_ANIM_EN)
- fall_col  out  3  column of falling piece (DROP_ANIM_EN)

Behaviour:
- Reset (rst_n low, asynchronous):
  - red_enc = 0, yellow_enc = 0, red_turn = 1.
  - busy, drop_ack, drop_ok, fall_valid, fall_row, fall_col = 0.
  - Move count = 0; state = IDLE.
- States: IDLE, SCAN, FALL (present only with DROP_ANIM_EN), REJECT.
- IDLE:
  - drop_req=1 with drop_col >= COLS → REJECT.
  - drop_req=1 with a valid column → latch the column, set scan row = ROWS-1, go to SCAN.
- SCAN: examines one row per cycle, with occ = red_enc|yellow_enc at (latched col, row).
  - occ=0 → commit the cell: set the bit in the current player's vector, toggle red_turn, increment move count, drop_ack=1, drop_ok=1, return to IDLE.
  - occ=1 and row>0 → row decrements by one.
  - occ=1 and row=0 → REJECT.
- REJECT: drop_ack=1, drop_ok=0; board and red_turn unchanged; return to IDLE.
- Latency: the request is sampled in cycle 0; with k occupied cells in the column, drop_ack is high in cycle k+2. A full or invalid column gives drop_ack in cycle 2 for an invalid column and cycle 8 for a full one.
- drop_ack is exactly one cycle wide. drop_ok is held until the next drop_ack.
- drop_req is ignored while busy; there is no queuing.
- new_game has top priority in any state:
  - Clears red_enc, yellow_enc and move count; sets red_turn=1.
  - Aborts any in-flight request without issuing drop_ack; state = IDLE.
- board_full=1 → requests are still processed; they reject naturally.
- A single commit never sets the same bit in both vectors; red_enc & yellow_enc = 0 always holds.

Optional Feature:
- DROP_ANIM_EN defined:
  - When SCAN finds the target row, do not commit; enter FALL with fall_valid=1, fall_col = latched col, fall_row = 0.
  - Each tick_en cycle increments fall_row.
  - In the cycle tick_en arrives with fall_row equal to the target row, commit as in SCAN, drop fall_valid to 0 and pulse drop_ack.
  - A target row of 0 commits on the first tick_en.
  - new_game during FALL aborts it and clears fall_valid.
- DROP_ANIM_EN undefined:
  - No FALL state; fall_valid, fall_row and fall_col are tied to 0; tick_en is ignored.

Decomposition:
- Package connect4_pkg holds:
  - Constants ROWS, COLS and CELLS = ROWS*COLS.
  - Widths: ROW_W=3, COL_W=3, CNT_W=6.
  - A state enum.
  - A cell_index(row,col) function returning col + COLS*row.
- Sub-module column_probe (combinational): given both encodings, col and row, returns the occupied bit. It is shared with future win-check logic.

Test Plan:
- Reset, then drop col 3 → drop_ack in cycle 2, drop_ok=1, red_enc bit 38 set, red_turn=0.
- Six drops in col 0, alternating players:
  - Pieces land at bits 35, 28, 21, 14, 7, 0.
  - The sixth request has ack in cycle 7.
  - A seventh request gives ack in cycle 8 with drop_ok=0, encodings unchanged and red_turn unchanged.
- drop_col=7 → drop_ack in cycle 2 with drop_ok=0, no state change; a drop_req pulse while busy is ignored and produces no second ack.
- Fill all 42 cells → board_full=1, red_enc and yellow_enc each have popcount 21, and red_enc & yellow_enc = 0.
- Assert new_game mid-SCAN with 3 cells occupied in the column → no drop_ack, encodings = 0, red_turn=1, busy=0 next cycle.
- DROP_ANIM_EN, drop into empty col 2 with tick_en every 4 cycles:
  - fall_row steps 0..5.
  - Commit of bit 37 and drop_ack occur on the tick where fall_row=5, and fall_valid falls in the same cycle.
